// File: rtl/saph_raster_arbiter.sv
// Round-robin arbiter that feeds one rasterizer from NUM_REQ shape sources.
// A single holding register decouples the sources from the rasterizer and can
// sustain one shape per clock. A burst limit lets a source keep the grant for up
// to MAX_BURST consecutive shapes while other sources are requesting.
module saph_raster_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 2,
    parameter int unsigned VTX_W     = 32,
    localparam int unsigned ID_W     = $clog2(NUM_REQ)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_trig,
    input  logic [NUM_REQ-1:0][1:0]                req_type,
    input  logic [NUM_REQ-1:0][3:0][VTX_W-1:0]     req_shape,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic                                   ras_trig,
    output logic [1:0]                             ras_type,
    output logic [3:0][VTX_W-1:0]                  ras_shape,
    output logic [ID_W-1:0]                        ras_src,
    input  logic                                   ras_ready,
    output logic                                   busy
);

    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    logic                    ras_trig_q, ras_trig_d;
    logic [1:0]              ras_type_q, ras_type_d;
    logic [3:0][VTX_W-1:0]   ras_shape_q, ras_shape_d;
    logic [ID_W-1:0]         ras_src_q, ras_src_d;
    logic [ID_W-1:0]         last_id_q, last_id_d;
    logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
    // Marks that last_id/burst_cnt describe a real grant; until the first grant
    // after reset the continue rule is disabled so that req 0 wins first.
    logic                    last_vld_q, last_vld_d;

    logic                    empty;
    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic                    xfer;
    int unsigned             idx;

    assign empty = ~ras_trig_q | ras_ready;
    assign xfer  = empty & grant_vld;

    // Grant selection: continue the current burst, else rotate from last_id+1.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = last_id_q;
        idx       = 0;
        if (last_vld_q && req_trig[last_id_q] && (32'(burst_cnt_q) + 32'd1 < MAX_BURST)) begin
            grant_vld = 1'b1;
        end else begin
            // The search ends at last_id itself, so a sole requester is always re-granted.
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                idx = (32'(last_id_q) + k) % NUM_REQ;
                if (!grant_vld && req_trig[idx]) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'(idx);
                end
            end
        end
    end

    // One-hot ready toward the granted source, only while the register can accept.
    always_comb begin
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = xfer & (grant_id == ID_W'(i));
        end
    end

    // Next state of the holding register and the round-robin pointer.
    always_comb begin
        ras_trig_d  = ras_trig_q & ~ras_ready;
        ras_type_d  = ras_type_q;
        ras_shape_d = ras_shape_q;
        ras_src_d   = ras_src_q;
        last_id_d   = last_id_q;
        burst_cnt_d = burst_cnt_q;
        last_vld_d  = last_vld_q;
        if (xfer) begin
            ras_trig_d  = 1'b1;
            ras_type_d  = req_type[grant_id];
            ras_shape_d = req_shape[grant_id];
            ras_src_d   = grant_id;
            last_id_d   = grant_id;
            last_vld_d  = 1'b1;
            if (last_vld_q && (grant_id == last_id_q)) begin
                if (32'(burst_cnt_q) + 32'd1 < MAX_BURST) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end else begin
                burst_cnt_d = '0;
            end
        end
    end

    // State registers with asynchronous reset; reset drops any held shape.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_trig_q  <= 1'b0;
            ras_type_q  <= '0;
            ras_shape_q <= '0;
            ras_src_q   <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
            burst_cnt_q <= '0;
            last_vld_q  <= 1'b0;
        end else begin
            ras_trig_q  <= ras_trig_d;
            ras_type_q  <= ras_type_d;
            ras_shape_q <= ras_shape_d;
            ras_src_q   <= ras_src_d;
            last_id_q   <= last_id_d;
            burst_cnt_q <= burst_cnt_d;
            last_vld_q  <= last_vld_d;
        end
    end

    assign ras_trig  = ras_trig_q;
    assign ras_type  = ras_type_q;
    assign ras_shape = ras_shape_q;
    assign ras_src   = ras_src_q;
    assign busy      = ras_trig_q | (|req_trig);

endmodule
